// File: rtl/datamem_arbiter.sv
// Two-requester round-robin arbiter and single-transfer sequencer for the 1 KiB data memory.
// Requests are legality-checked on accept; illegal ones get an error response without a memory access.
module datamem_arbiter #(
  parameter int unsigned MEM_SIZE = 1024,
  parameter int unsigned ADDR_W   = 64,
  parameter int unsigned DATA_W   = 64
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              r0_req_valid,
  output logic              r0_req_ready,
  input  logic              r0_req_write,
  input  logic [ADDR_W-1:0] r0_req_addr,
  input  logic [DATA_W-1:0] r0_req_wdata,
  input  logic [3:0]        r0_req_size,
  output logic              r0_rsp_valid,
  output logic [DATA_W-1:0] r0_rsp_rdata,
  output logic              r0_rsp_err,

  input  logic              r1_req_valid,
  output logic              r1_req_ready,
  input  logic              r1_req_write,
  input  logic [ADDR_W-1:0] r1_req_addr,
  input  logic [DATA_W-1:0] r1_req_wdata,
  input  logic [3:0]        r1_req_size,
  output logic              r1_rsp_valid,
  output logic [DATA_W-1:0] r1_rsp_rdata,
  output logic              r1_rsp_err,

  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  output logic [DATA_W-1:0] mem_write_data,
  output logic [3:0]        mem_xfer_size,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]        state;
  logic              last_grant;
  logic              owner;
  logic              lat_write;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [3:0]        lat_size;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

  logic              grant0, grant1, accept;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [3:0]        sel_size;
  logic              size_ok, align_ok, bound_ok, legal;
  logic [ADDR_W-1:0] size_mask;
  logic [ADDR_W:0]   end_addr;
  logic [DATA_W-1:0] rd_masked;
  logic              in_access, in_resp;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    grant0       = r0_req_valid && (!r1_req_valid || last_grant);
    grant1       = r1_req_valid && (!r0_req_valid || !last_grant);
    r0_req_ready = (state == IDLE) && !reset && grant0;
    r1_req_ready = (state == IDLE) && !reset && grant1;
    accept       = r0_req_ready || r1_req_ready;
  end

  always_comb begin
    sel_write = r0_req_write;
    sel_addr  = r0_req_addr;
    sel_wdata = r0_req_wdata;
    sel_size  = r0_req_size;
    if (r1_req_ready) begin
      sel_write = r1_req_write;
      sel_addr  = r1_req_addr;
      sel_wdata = r1_req_wdata;
      sel_size  = r1_req_size;
    end
  end

  // End address is formed one bit wider so addresses near the top of the space cannot wrap.
  always_comb begin
    size_ok   = (sel_size == 4'd1) || (sel_size == 4'd2) ||
                (sel_size == 4'd4) || (sel_size == 4'd8);
    size_mask = {{(ADDR_W-4){1'b0}}, sel_size - 4'd1};
    align_ok  = (sel_addr & size_mask) == '0;
    end_addr  = {1'b0, sel_addr} + {{(ADDR_W-3){1'b0}}, sel_size};
    bound_ok  = end_addr <= (ADDR_W+1)'(MEM_SIZE);
    legal     = size_ok && align_ok && bound_ok;
  end

  always_comb begin
    rd_masked = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (4'(i) < lat_size) rd_masked[8*i +: 8] = mem_read_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      lat_write   <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_size    <= 4'd8;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner       <= r1_req_ready;
            rsp_rdata_q <= '0;
            rsp_err_q   <= !legal;
            // Memory-facing registers only move for legal requests so the bus holds its last transfer.
            if (legal) begin
              lat_write <= sel_write;
              lat_addr  <= sel_addr;
              lat_wdata <= sel_wdata;
              lat_size  <= sel_size;
              state     <= ACCESS;
            end else begin
              state     <= RESP;
            end
          end
        end
        ACCESS: begin
          if (!lat_write) rsp_rdata_q <= rd_masked;
          state <= RESP;
        end
        RESP: begin
          last_grant <= owner;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    in_access        = (state == ACCESS);
    in_resp          = (state == RESP) && !reset;
    mem_address      = lat_addr;
    mem_write_data   = lat_wdata;
    mem_xfer_size    = lat_size;
    mem_write_enable = in_access && lat_write && !reset;
    mem_read_enable  = in_access && !lat_write && !reset;
    r0_rsp_valid     = in_resp && !owner;
    r0_rsp_rdata     = (in_resp && !owner) ? rsp_rdata_q : '0;
    r0_rsp_err       = in_resp && !owner && rsp_err_q;
    r1_rsp_valid     = in_resp && owner;
    r1_rsp_rdata     = (in_resp && owner) ? rsp_rdata_q : '0;
    r1_rsp_err       = in_resp && owner && rsp_err_q;
  end

endmodule
